// File: rtl/serial_xnor_comparator.sv
// Bit-serial word comparator: XNORs a/b per accepted bit over a WIDTH-bit word and
// reports equality, mismatch count and index of the first differing bit.
module serial_xnor_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_diff,
  output logic             diff_seen
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] bit_idx, bit_idx_nx;
  logic [CNT_W-1:0] cnt_nx, first_nx;
  logic             busy_nx, done_nx, equal_nx, seen_nx;
  logic             match;

  assign match = (a & b) | (~a & ~b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      mismatch_cnt <= '0;
      first_diff   <= '0;
      diff_seen    <= 1'b0;
    end else begin
      state        <= state_nx;
      bit_idx      <= bit_idx_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      equal        <= equal_nx;
      mismatch_cnt <= cnt_nx;
      first_diff   <= first_nx;
      diff_seen    <= seen_nx;
    end
  end

  // Results hold by default so they stay stable from done until the next start.
  always_comb begin
    state_nx   = state;
    bit_idx_nx = bit_idx;
    busy_nx    = busy;
    done_nx    = 1'b0;
    equal_nx   = equal;
    cnt_nx     = mismatch_cnt;
    first_nx   = first_diff;
    seen_nx    = diff_seen;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = RUN;
          bit_idx_nx = '0;
          cnt_nx     = '0;
          first_nx   = '0;
          seen_nx    = 1'b0;
          equal_nx   = 1'b0;
          busy_nx    = 1'b1;
        end
      end
      RUN: begin
        if (bit_valid) begin
          bit_idx_nx = bit_idx + 1'b1;
          if (!match) begin
            cnt_nx = mismatch_cnt + 1'b1;
            if (!diff_seen) begin
              first_nx = bit_idx;
              seen_nx  = 1'b1;
            end
          end
          if (bit_idx == LAST_IDX) begin
            state_nx = DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            equal_nx = (cnt_nx == '0);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
